// File: rtl/radar_scan_sequencer.sv
// Purpose : sequences one radar sweep: servo move, settle, ultrasonic trigger, echo timing,
//           then hands {angle, distance} to the register block; sweeps ping-pong min..max.
// Latency : trigger end to res_valid = echo delay + echo width + ~3 cycles (2-flop echo sync).
// Backpr. : res_ready low holds the FSM in REPORT with a stable payload; nothing is dropped.
// Ports   : ACLK/ARESETN (async active-low); cfg_* config (sampled at start and between points);
//           servo_angle/servo_update to PWM; us_trig/us_echo ultrasonic pins; res_* result
//           handshake; busy = FSM not idle.
// Option  : RADAR_SWEEP_IRQ_EN adds irq_clr/sweep_irq (sticky flag on every sweep reversal).
module radar_scan_sequencer #(
  parameter int ANGLE_W      = 8,
  parameter int DIST_W       = 22,
  parameter int SETTLE_W     = 24,
  parameter int TRIG_CYCLES  = 1000,
  parameter int ECHO_TIMEOUT = 2500000
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cfg_enable,
  input  logic [ANGLE_W-1:0]  cfg_min_deg,
  input  logic [ANGLE_W-1:0]  cfg_max_deg,
  input  logic [ANGLE_W-1:0]  cfg_step_deg,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic [ANGLE_W-1:0]  servo_angle,
  output logic                servo_update,
  output logic                us_trig,
  input  logic                us_echo,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ANGLE_W-1:0]  res_angle,
  output logic [DIST_W-1:0]   res_dist,
  output logic                res_timeout,
  output logic                busy
`ifdef RADAR_SWEEP_IRQ_EN
  ,
  input  logic                irq_clr,
  output logic                sweep_irq
`endif
);

  // One shared counter serves settle, trigger, echo-wait and echo-measure phases.
  localparam int CNT_W = (SETTLE_W > DIST_W) ? SETTLE_W : DIST_W;

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_TRIG, S_WAIT, S_MEAS, S_REPORT, S_STEP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [ANGLE_W-1:0]  angle_q, angle_d;
  logic                dir_dn_q, dir_dn_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [ANGLE_W-1:0]  res_angle_q, res_angle_d;
  logic [DIST_W-1:0]   res_dist_q, res_dist_d;
  logic                res_to_q, res_to_d;
  logic                echo_meta_q, echo_sync_q;
  logic                reverse;

  // Next-angle arithmetic is one bit wider so overflow/underflow are visible.
  logic [ANGLE_W:0]    up_sum, dn_diff;
  logic                degenerate;

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign up_sum     = {1'b0, angle_q} + {1'b0, cfg_step_deg};
  assign dn_diff    = {1'b0, angle_q} - {1'b0, cfg_step_deg};
  assign degenerate = (cfg_step_deg == '0) || (cfg_min_deg >= cfg_max_deg);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    angle_d     = angle_q;
    dir_dn_d    = dir_dn_q;
    settle_d    = settle_q;
    res_angle_d = res_angle_q;
    res_dist_d  = res_dist_q;
    res_to_d    = res_to_q;
    reverse     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_enable) begin
          state_d  = S_MOVE;
          angle_d  = cfg_min_deg;
          dir_dn_d = 1'b0;
          settle_d = cfg_settle;
        end
      end
      S_MOVE: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        // A zero settle still spends one cycle here.
        if (settle_q == '0 || cnt_inc >= CNT_W'(settle_q)) begin
          state_d = S_TRIG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT: begin
        if (echo_sync_q) begin
          // The cycle that saw the rise already counts as one high cycle.
          state_d = S_MEAS;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(ECHO_TIMEOUT - 1)) begin
          state_d     = S_REPORT;
          res_angle_d = angle_q;
          res_dist_d  = '1;
          res_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEAS: begin
        if (!echo_sync_q) begin
          state_d     = S_REPORT;
          res_angle_d = angle_q;
          res_dist_d  = cnt_q[DIST_W-1:0];
          res_to_d    = 1'b0;
        end else if (cnt_inc >= CNT_W'(ECHO_TIMEOUT)) begin
          state_d     = S_REPORT;
          res_angle_d = angle_q;
          res_dist_d  = '1;
          res_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_REPORT: begin
        if (res_ready) state_d = S_STEP;
      end
      S_STEP: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_MOVE;
          settle_d = cfg_settle;
          if (degenerate) begin
            angle_d  = cfg_min_deg;
            dir_dn_d = 1'b0;
          end else if (!dir_dn_q) begin
            if (up_sum >= {1'b0, cfg_max_deg}) begin
              angle_d  = cfg_max_deg;
              dir_dn_d = 1'b1;
            end else begin
              angle_d = up_sum[ANGLE_W-1:0];
            end
          end else begin
            if (dn_diff[ANGLE_W] || dn_diff <= {1'b0, cfg_min_deg}) begin
              angle_d  = cfg_min_deg;
              dir_dn_d = 1'b0;
            end else begin
              angle_d = dn_diff[ANGLE_W-1:0];
            end
          end
          reverse = (dir_dn_d != dir_dn_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      angle_q     <= '0;
      dir_dn_q    <= 1'b0;
      settle_q    <= '0;
      res_angle_q <= '0;
      res_dist_q  <= '0;
      res_to_q    <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      angle_q     <= angle_d;
      dir_dn_q    <= dir_dn_d;
      settle_q    <= settle_d;
      res_angle_q <= res_angle_d;
      res_dist_q  <= res_dist_d;
      res_to_q    <= res_to_d;
      echo_meta_q <= us_echo;
      echo_sync_q <= echo_meta_q;
    end
  end

`ifdef RADAR_SWEEP_IRQ_EN
  logic sweep_irq_q;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)     sweep_irq_q <= 1'b0;
    else if (reverse) sweep_irq_q <= 1'b1;   // set beats a simultaneous clear
    else if (irq_clr) sweep_irq_q <= 1'b0;
  end
  assign sweep_irq = sweep_irq_q;
`else
  logic unused_reverse;
  assign unused_reverse = reverse;
`endif

  // Strobe/pin outputs decode straight from state so an async reset clears them at once.
  assign servo_angle  = angle_q;
  assign servo_update = (state_q == S_MOVE);
  assign us_trig      = (state_q == S_TRIG);
  assign res_valid    = (state_q == S_REPORT);
  assign res_angle    = res_angle_q;
  assign res_dist     = res_dist_q;
  assign res_timeout  = res_to_q;
  assign busy         = (state_q != S_IDLE);

endmodule
